// File: rtl/fp_unpack_if.sv
// Handshake bundle between an operand source and the IEEE-754 unpacker.
interface fp_unpack_if #(
  parameter int EW = 11,
  parameter int FW = 52
);
  logic           in_valid;
  logic           in_ready;
  logic [EW+FW:0] in_word;
  logic           out_valid;
  logic           out_ready;
  logic           s_out;
  logic [EW+1:0]  e_out;
  logic [FW:0]    f_out;
  logic           zero;
  logic           denorm;
  logic           inf;
  logic           nan;
  logic           snan;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, s_out, e_out, f_out, zero, denorm, inf, nan, snan
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, s_out, e_out, f_out, zero, denorm, inf, nan, snan
  );
endinterface

// File: rtl/fp_unpack.sv
// IEEE-754 operand unpacker: classify, unbias exponent, expose hidden bit,
// and normalize denormals up to STEP positions per cycle.
module fp_unpack #(
  parameter int EW   = 11,
  parameter int FW   = 52,
  parameter int STEP = 8
) (
  input logic       clk,
  input logic       rst_n,
  fp_unpack_if.slave u
);
  localparam int            LZW  = $clog2(FW + 2);
  localparam logic [EW+1:0] BIAS = (EW+2)'((1 << (EW - 1)) - 1);

  typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic inf;
    logic nan;
    logic snan;
  } flags_t;

  state_t        st_q, st_nx;
  logic          s_q, s_nx;
  logic [EW+1:0] e_q, e_nx;
  logic [FW:0]   f_q, f_nx;
  flags_t        fl_q, fl_nx;
  logic [LZW-1:0] lz, k;

  wire          in_s  = u.in_word[EW+FW];
  wire [EW-1:0] in_ex = u.in_word[FW +: EW];
  wire [FW-1:0] in_fr = u.in_word[FW-1:0];
  wire          ex_z  = ~|in_ex;
  wire          ex_m  = &in_ex;
  wire          fr_z  = ~|in_fr;

  // Leading-zero count of the working significand; last hit from the top wins.
  always_comb begin
    lz = LZW'(FW + 1);
    for (int i = 0; i <= FW; i++)
      if (f_q[i]) lz = LZW'(FW - i);
    k = (lz > LZW'(STEP)) ? LZW'(STEP) : lz;
  end

  always_comb begin
    st_nx = st_q;
    s_nx  = s_q;
    e_nx  = e_q;
    f_nx  = f_q;
    fl_nx = fl_q;
    case (st_q)
      IDLE: if (u.in_valid) begin
        s_nx  = in_s;
        fl_nx = '0;
        st_nx = OUT;
        if (ex_z && fr_z) begin
          fl_nx.zero = 1'b1;
          e_nx       = '0;
          f_nx       = '0;
        end else if (ex_z) begin
          fl_nx.denorm = 1'b1;
          e_nx         = (EW+2)'(1) - BIAS;
          f_nx         = {1'b0, in_fr};
          st_nx        = NORM;
        end else if (ex_m) begin
          e_nx = BIAS + (EW+2)'(1);
          if (fr_z) begin
            fl_nx.inf = 1'b1;
            f_nx      = '0;
          end else begin
            fl_nx.nan  = 1'b1;
            fl_nx.snan = ~in_fr[FW-1];
            f_nx       = {1'b0, in_fr};
          end
        end else begin
          e_nx = {2'b00, in_ex} - BIAS;
          f_nx = {1'b1, in_fr};
        end
      end
      NORM: begin
        f_nx = f_q << k;
        e_nx = e_q - (EW+2)'(k);
        if (f_nx[FW]) st_nx = OUT;
      end
      OUT: if (u.out_ready) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      s_q  <= 1'b0;
      e_q  <= '0;
      f_q  <= '0;
      fl_q <= '0;
    end else begin
      st_q <= st_nx;
      s_q  <= s_nx;
      e_q  <= e_nx;
      f_q  <= f_nx;
      fl_q <= fl_nx;
    end
  end

  assign u.in_ready  = (st_q == IDLE);
  assign u.out_valid = (st_q == OUT);
  assign u.s_out     = s_q;
  assign u.e_out     = e_q;
  assign u.f_out     = f_q;
  assign u.zero      = fl_q.zero;
  assign u.denorm    = fl_q.denorm;
  assign u.inf       = fl_q.inf;
  assign u.nan       = fl_q.nan;
  assign u.snan      = fl_q.snan;
endmodule

// File: tb/tb_fp_unpack.sv
// Scoreboard bench for fp_unpack: directed and random operands, backpressure, mid-op reset.
module tb_fp_unpack;
  localparam int EW = 11, FW = 52, STEP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_unpack_if #(.EW(EW), .FW(FW)) bus ();
  fp_unpack #(.EW(EW), .FW(FW), .STEP(STEP)) dut (.clk(clk), .rst_n(rst_n), .u(bus));

  typedef struct {
    logic [63:0] w;
    logic        s;
    logic [12:0] e;
    logic [52:0] f;
    logic [4:0]  fl;   // {zero, denorm, inf, nan, snan}
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   bp_en = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: real-valued IEEE rules, denormal normalized one bit at a time.
  function automatic exp_t model(input logic [63:0] w);
    exp_t        r;
    logic [10:0] ex = w[62:52];
    logic [51:0] fr = w[51:0];
    logic [52:0] f;
    int          e, lz;
    r.w = w; r.s = w[63]; r.fl = 5'b0; r.lat = 1; r.acc = 0;
    if (ex == 0 && fr == 0) begin
      r.e = 13'd0; r.f = 53'd0; r.fl = 5'b10000;
    end else if (ex == 0) begin
      f = {1'b0, fr}; e = -1022; lz = 0;
      while (!f[52]) begin f = f << 1; e--; lz++; end
      r.e = 13'(e); r.f = f; r.fl = 5'b01000;
      r.lat = 1 + (lz + STEP - 1) / STEP;
    end else if (ex == 11'h7FF) begin
      r.e = 13'd1024;
      if (fr == 0) begin r.f = 53'd0; r.fl = 5'b00100; end
      else begin r.f = {1'b0, fr}; r.fl = {3'b000, 1'b1, ~fr[51]}; end
    end else begin
      r.e = 13'(int'(ex) - 1023); r.f = {1'b1, fr};
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] r = {$urandom(), $urandom()};
    logic        s = r[63];
    logic [10:0] ex;
    logic [51:0] fr = r[51:0];
    case ($urandom_range(0, 5))
      0: ex = 11'($urandom_range(1, 2046));
      1: begin ex = 11'd0; fr = 52'd0; end
      2: begin ex = 11'd0; fr = fr >> $urandom_range(0, 51); if (fr == 0) fr = 52'd1; end
      3: begin ex = 11'h7FF; fr = 52'd0; end
      4: begin ex = 11'h7FF; if (fr == 0) fr = 52'd1; end
      default: ex = r[62] ? 11'd1 : 11'd2046;
    endcase
    return {s, ex, fr};
  endfunction

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency, stability under stall, result compare, in_ready recovery.
  logic [71:0] held, cur;
  bit stall = 0, seen = 0, chk_rdy = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall = 0; seen = 0; chk_rdy = 0;
    end else begin
      if (chk_rdy) begin chk("in_ready_after_hs", 80'(bus.in_ready), 80'd1); chk_rdy = 0; end
      if (bus.out_valid) begin
        cur = {bus.s_out, bus.e_out, bus.f_out, bus.zero, bus.denorm, bus.inf, bus.nan, bus.snan};
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got 1 want 0");
        end else begin
          if (!seen) begin
            chk($sformatf("latency %h", q[0].w), 80'(cyc - q[0].acc), 80'(q[0].lat));
            seen = 1;
          end
          if (stall) chk("stable_under_stall", 80'(cur), 80'(held));
          if (!bus.out_ready) begin
            stall = 1; held = cur;
            chk("in_ready_busy", 80'(bus.in_ready), 80'd0);
          end else begin
            chk($sformatf("sign %h", q[0].w),  80'(bus.s_out), 80'(q[0].s));
            chk($sformatf("exp %h", q[0].w),   80'(bus.e_out), 80'(q[0].e));
            chk($sformatf("frac %h", q[0].w),  80'(bus.f_out), 80'(q[0].f));
            chk($sformatf("flags %h", q[0].w), 80'(cur[4:0]),  80'(q[0].fl));
            void'(q.pop_front());
            stall = 0; seen = 0; chk_rdy = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] w);
    int   n = 0;
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_word = w;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout %h: got in_ready 0 want 1", w);
    end else begin
      e = model(w); e.acc = cyc; q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || !bus.in_ready) && n < 2000) begin @(negedge clk); n++; end
    if (q.size() != 0 || !bus.in_ready) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 80'(bus.out_valid), 80'd0);
    chk({tag, "_in_ready"},  80'(bus.in_ready),  80'd1);
    chk({tag, "_outputs"},
        80'({bus.s_out, bus.e_out, bus.f_out, bus.zero, bus.denorm, bus.inf, bus.nan, bus.snan}),
        80'd0);
  endtask

  logic [63:0] dir [10] = '{64'h3FF0000000000000, 64'hC004000000000000, 64'h8000000000000000,
                            64'h0000000000000001, 64'h0008000000000000, 64'h7FF0000000000000,
                            64'h7FF0000000000001, 64'hFFF8000000000000, 64'h7FEFFFFFFFFFFFFF,
                            64'h0010000000000000};

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_word = '0; bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (dir[i]) send(dir[i]);
    wait_drain();

    // Backpressure: hold result for 5 cycles while a new word is offered.
    bus.out_ready = 1'b0;
    send(64'h3FF0000000000000);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_out_valid", 80'(bus.out_valid), 80'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_word = 64'h4000000000000000;
    repeat (5) @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("bp_no_capture", 80'(bus.out_valid), 80'd0);

    // Reset while normalizing the minimum denormal.
    send(64'h0000000000000001);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midop_reset");
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(64'h3FF0000000000000);
    wait_drain();

    bp_en = 1;
    repeat (300) send(rand_word());
    wait_drain();
    bp_en = 0;
    bus.out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
